mp_cache_tag_ctrl: RTL

//   Initiator for the 32x23 single-port tag SRAM (mp_cache_tag_array).

---
 rtl/mp_cache_tag_ctrl.sv | 242 ++++++++++++++++++++++++
 1 files changed

// File: rtl/mp_cache_tag_ctrl.sv
// Tag-SRAM initiator for a 32x23 single-port tag array: zero sweep after reset, then lookup/fill/invalidate.
// Optional hit/miss counters are built when MP_TAG_CTRL_STATS_EN is defined.
module mp_cache_tag_ctrl #(
    parameter int unsigned TAG_W = 21,
    parameter int unsigned IDX_W = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [1:0]       req_op,
    input  logic [IDX_W-1:0] req_idx,
    input  logic [TAG_W-1:0] req_tag,
    input  logic             req_dirty,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_hit,
    output logic             rsp_vbit,
    output logic             rsp_dirty,
    output logic [TAG_W-1:0] rsp_tag,
    output logic             init_done,
    output logic             csb0,
    output logic             web0,
    output logic [IDX_W-1:0] addr0,
    output logic [TAG_W+1:0] din0,
    input  logic [TAG_W+1:0] dout0
`ifdef MP_TAG_CTRL_STATS_EN
    ,
    output logic [15:0]      stat_hits,
    output logic [15:0]      stat_misses
`endif
);

    localparam int unsigned WORD_W   = TAG_W + 2;
    localparam int unsigned ENTRIES  = 1 << IDX_W;
    localparam int unsigned LAST_IDX = ENTRIES - 1;

    localparam logic [1:0] OP_FILL  = 2'b01;
    localparam logic [1:0] OP_INVAL = 2'b10;

    localparam logic [1:0] S_INIT = 2'd0;
    localparam logic [1:0] S_BUSY = 2'd1;
    localparam logic [1:0] S_RSP  = 2'd2;
    localparam logic [1:0] S_IDLE = 2'd3;

    logic [1:0]       r_state;
    logic [IDX_W-1:0] r_cnt;
    logic             r_init_done;
    logic             r_rsp_valid;
    logic             r_rsp_hit;
    logic             r_rsp_vbit;
    logic             r_rsp_dirty;
    logic [TAG_W-1:0] r_rsp_tag;
    logic             r_is_lookup;
    logic [TAG_W-1:0] r_req_tag;

    logic [1:0]       w_state_nxt;
    logic [IDX_W-1:0] w_cnt_nxt;
    logic             w_init_done_nxt;
    logic             w_rsp_valid_nxt;
    logic             w_rsp_hit_nxt;
    logic             w_rsp_vbit_nxt;
    logic             w_rsp_dirty_nxt;
    logic [TAG_W-1:0] w_rsp_tag_nxt;
    logic             w_is_lookup_nxt;
    logic [TAG_W-1:0] w_req_tag_nxt;
    logic             w_accept;

    // Stored word layout: {valid, dirty, tag}
    logic             w_stored_valid;
    logic             w_stored_dirty;
    logic [TAG_W-1:0] w_stored_tag;
    logic             w_hit;

    assign w_stored_valid = dout0[WORD_W-1];
    assign w_stored_dirty = dout0[WORD_W-2];
    assign w_stored_tag   = dout0[TAG_W-1:0];
    assign w_hit          = w_stored_valid && (w_stored_tag == r_req_tag);

`ifdef MP_TAG_CTRL_STATS_EN
    logic [15:0] r_stat_hits;
    logic [15:0] r_stat_misses;
    logic [15:0] w_stat_hits_nxt;
    logic [15:0] w_stat_misses_nxt;
`endif

    // Next-state, SRAM port and handshake decode
    always_comb begin
        w_state_nxt     = r_state;
        w_cnt_nxt       = r_cnt;
        w_init_done_nxt = r_init_done;
        w_rsp_valid_nxt = r_rsp_valid;
        w_rsp_hit_nxt   = r_rsp_hit;
        w_rsp_vbit_nxt  = r_rsp_vbit;
        w_rsp_dirty_nxt = r_rsp_dirty;
        w_rsp_tag_nxt   = r_rsp_tag;
        w_is_lookup_nxt = r_is_lookup;
        w_req_tag_nxt   = r_req_tag;
        w_accept        = 1'b0;
        req_ready       = 1'b0;
        csb0            = 1'b1;
        web0            = 1'b1;
        addr0           = '0;
        din0            = '0;
`ifdef MP_TAG_CTRL_STATS_EN
        w_stat_hits_nxt   = r_stat_hits;
        w_stat_misses_nxt = r_stat_misses;
`endif

        case (r_state)
            S_INIT: begin
                csb0      = 1'b0;
                web0      = 1'b0;
                addr0     = r_cnt;
                w_cnt_nxt = IDX_W'(r_cnt + 1'b1);
                if (r_cnt == IDX_W'(LAST_IDX)) begin
                    w_state_nxt     = S_IDLE;
                    w_init_done_nxt = 1'b1;
                end
            end
            S_IDLE: begin
                req_ready = 1'b1;
                w_accept  = req_valid;
            end
            S_BUSY: begin
                w_rsp_valid_nxt = 1'b1;
                w_state_nxt     = S_RSP;
                if (r_is_lookup) begin
                    w_rsp_hit_nxt   = w_hit;
                    w_rsp_vbit_nxt  = w_stored_valid;
                    w_rsp_dirty_nxt = w_stored_dirty;
                    w_rsp_tag_nxt   = w_stored_tag;
`ifdef MP_TAG_CTRL_STATS_EN
                    if (w_hit) begin
                        if (r_stat_hits != 16'hFFFF) w_stat_hits_nxt = 16'(r_stat_hits + 16'd1);
                    end else begin
                        if (r_stat_misses != 16'hFFFF) w_stat_misses_nxt = 16'(r_stat_misses + 16'd1);
                    end
`endif
                end else begin
                    w_rsp_hit_nxt   = 1'b0;
                    w_rsp_vbit_nxt  = 1'b0;
                    w_rsp_dirty_nxt = 1'b0;
                    w_rsp_tag_nxt   = '0;
                end
            end
            S_RSP: begin
                req_ready = rsp_ready;
                if (rsp_ready) begin
                    w_rsp_valid_nxt = 1'b0;
                    w_accept        = req_valid;
                    if (!req_valid) w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_INIT;
            end
        endcase

        // Accepted request is issued to the SRAM in the accept cycle itself
        if (w_accept) begin
            csb0            = 1'b0;
            addr0           = req_idx;
            w_req_tag_nxt   = req_tag;
            w_is_lookup_nxt = 1'b1;
            w_state_nxt     = S_BUSY;
            case (req_op)
                OP_FILL: begin
                    web0            = 1'b0;
                    din0            = {1'b1, req_dirty, req_tag};
                    w_is_lookup_nxt = 1'b0;
                end
                OP_INVAL: begin
                    web0            = 1'b0;
                    w_is_lookup_nxt = 1'b0;
                end
                default: begin
                    web0 = 1'b1;
                end
            endcase
        end

        // SRAM has no reset: hold a harmless zero write to entry 0 while in reset
        if (!rst_n) begin
            csb0  = 1'b0;
            web0  = 1'b0;
            addr0 = '0;
            din0  = '0;
        end
    end

    // State and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_INIT;
            r_cnt       <= '0;
            r_init_done <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_hit   <= 1'b0;
            r_rsp_vbit  <= 1'b0;
            r_rsp_dirty <= 1'b0;
            r_rsp_tag   <= '0;
            r_is_lookup <= 1'b0;
            r_req_tag   <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_init_done <= w_init_done_nxt;
            r_rsp_valid <= w_rsp_valid_nxt;
            r_rsp_hit   <= w_rsp_hit_nxt;
            r_rsp_vbit  <= w_rsp_vbit_nxt;
            r_rsp_dirty <= w_rsp_dirty_nxt;
            r_rsp_tag   <= w_rsp_tag_nxt;
            r_is_lookup <= w_is_lookup_nxt;
            r_req_tag   <= w_req_tag_nxt;
        end
    end

`ifdef MP_TAG_CTRL_STATS_EN
    // Saturating lookup hit/miss counters
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stat_hits   <= '0;
            r_stat_misses <= '0;
        end else begin
            r_stat_hits   <= w_stat_hits_nxt;
            r_stat_misses <= w_stat_misses_nxt;
        end
    end

    assign stat_hits   = r_stat_hits;
    assign stat_misses = r_stat_misses;
`endif

    assign rsp_valid = r_rsp_valid;
    assign rsp_hit   = r_rsp_hit;
    assign rsp_vbit  = r_rsp_vbit;
    assign rsp_dirty = r_rsp_dirty;
    assign rsp_tag   = r_rsp_tag;
    assign init_done = r_init_done;

endmodule
